// File: rtl/uart_pkg.sv
// Shared UART register map constants and the configuration sequencer state type.
package uart_pkg;

  localparam logic [2:0] ADDR_RBR_THR_DLL = 3'd0;
  localparam logic [2:0] ADDR_IER_DLM     = 3'd1;
  localparam logic [2:0] ADDR_FCR         = 3'd2;
  localparam logic [2:0] ADDR_LCR         = 3'd3;

  localparam int         LCR_DLAB_BIT     = 7;
  localparam logic [7:0] LCR_DLAB_MASK    = 8'h1 << LCR_DLAB_BIT;

  typedef enum logic [2:0] {
    IDLE,
    DLAB_SET,
    DLL,
    DLM,
    LCR,
    FCR,
    DONE
  } cfg_state_t;

endpackage

// File: rtl/uart_cfg_sequencer.sv
// Shares the regs_uart bus between a host port and an atomic divisor/LCR/FCR
// programming burst, so the host never sees the register map with DLAB=1.
module uart_cfg_sequencer
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [15:0] cfg_div_i,
  input  logic [7:0]  cfg_lcr_i,
  input  logic [7:0]  cfg_fcr_i,
  input  logic        host_req_i,
  input  logic        host_wr_i,
  input  logic [2:0]  host_addr_i,
  input  logic [7:0]  host_din_i,
  output logic        host_gnt_o,
  output logic        wr_o,
  output logic        rd_o,
  output logic [2:0]  addr_o,
  output logic [7:0]  din_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  cfg_state_t  state, state_nxt;
  logic        last_host;
  logic        err_flag, err_nxt;
  logic        host_win, cfg_win;
  logic [15:0] div;
  logic [6:0]  lcr;
  logic [7:0]  fcr;
  logic        lcr_dlab_unused;

  // DLAB is owned by the sequencer; the requester's bit 7 is discarded.
  assign lcr_dlab_unused = cfg_lcr_i[LCR_DLAB_BIT];

  // Host first, but a host that held the bus last cycle yields to a waiting request.
  always_comb begin
    host_win = 1'b0;
    cfg_win  = 1'b0;
    if (rst_n && state == IDLE) begin
      host_win = host_req_i && !(last_host && cfg_valid_i);
      cfg_win  = cfg_valid_i && !host_win;
    end
  end

  always_comb begin
    state_nxt   = state;
    err_nxt     = err_flag;
    host_gnt_o  = host_win;
    cfg_ready_o = cfg_win;
    wr_o        = 1'b0;
    rd_o        = 1'b0;
    addr_o      = '0;
    din_o       = '0;
    busy_o      = (state != IDLE);
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state)
      IDLE: begin
        if (host_win) begin
          wr_o   = host_wr_i;
          rd_o   = !host_wr_i;
          addr_o = host_addr_i;
          din_o  = host_din_i;
        end else if (cfg_win) begin
          if (cfg_div_i == 16'd0) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = DLAB_SET;
          end
        end
      end
      DLAB_SET: begin
        wr_o      = 1'b1;
        addr_o    = ADDR_LCR;
        din_o     = LCR_DLAB_MASK;
        state_nxt = DLL;
      end
      DLL: begin
        wr_o      = 1'b1;
        addr_o    = ADDR_RBR_THR_DLL;
        din_o     = div[7:0];
        state_nxt = DLM;
      end
      DLM: begin
        wr_o      = 1'b1;
        addr_o    = ADDR_IER_DLM;
        din_o     = div[15:8];
        state_nxt = LCR;
      end
      LCR: begin
        wr_o      = 1'b1;
        addr_o    = ADDR_LCR;
        din_o     = {1'b0, lcr};
        state_nxt = FCR;
      end
      FCR: begin
        wr_o      = 1'b1;
        addr_o    = ADDR_FCR;
        din_o     = fcr;
        state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        err_o     = err_flag;
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_host <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_host <= host_win;
      err_flag  <= err_nxt;
    end
  end

  // Request fields are only consumed after a handshake, so they need no reset.
  always_ff @(posedge clk) begin
    if (cfg_win) begin
      div <= cfg_div_i;
      lcr <= cfg_lcr_i[6:0];
      fcr <= cfg_fcr_i;
    end
  end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Scoreboard bench for uart_cfg_sequencer: a queue-based reference model predicts
// every cycle's bus/handshake outputs; a negedge monitor compares them.
module tb_uart_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [15:0] cfg_div_i = '0;
  logic [7:0]  cfg_lcr_i = '0;
  logic [7:0]  cfg_fcr_i = '0;
  logic        host_req_i = 1'b0;
  logic        host_wr_i = 1'b0;
  logic [2:0]  host_addr_i = '0;
  logic [7:0]  host_din_i = '0;
  logic        host_gnt_o;
  logic        wr_o, rd_o;
  logic [2:0]  addr_o;
  logic [7:0]  din_o;
  logic        busy_o, done_o, err_o;

  always #5 clk = ~clk;

  uart_cfg_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_div_i   (cfg_div_i),
    .cfg_lcr_i   (cfg_lcr_i),
    .cfg_fcr_i   (cfg_fcr_i),
    .host_req_i  (host_req_i),
    .host_wr_i   (host_wr_i),
    .host_addr_i (host_addr_i),
    .host_din_i  (host_din_i),
    .host_gnt_o  (host_gnt_o),
    .wr_o        (wr_o),
    .rd_o        (rd_o),
    .addr_o      (addr_o),
    .din_o       (din_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  typedef struct {
    int          cyc;
    logic [17:0] bus;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] seq[$];
  bit          last_host = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  m_lcr = '0, m_dll = '0, m_dlm = '0;

  // {gnt, ready, busy, wr, rd, addr[2:0], din[7:0], done, err}
  function automatic logic [17:0] pack(input bit g, r, b, w, rd, input logic [2:0] a,
                                       input logic [7:0] d, input bit dn, er);
    return {g, r, b, w, rd, a, d, dn, er};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic cyc_drive(input bit rn, input bit hreq, input bit hwr, input logic [2:0] ha,
                           input logic [7:0] hd, input bit cv, input logic [15:0] dv,
                           input logic [7:0] lc, input logic [7:0] fc);
    logic [17:0] e;
    bit g, r;
    @(posedge clk);
    #1;
    rst_n = rn; host_req_i = hreq; host_wr_i = hwr; host_addr_i = ha; host_din_i = hd;
    cfg_valid_i = cv; cfg_div_i = dv; cfg_lcr_i = lc; cfg_fcr_i = fc;
    cyc++;
    e = '0;
    if (!rn) begin
      seq.delete();
      last_host = 1'b0;
    end else if (seq.size() == 0) begin
      g = hreq && !(last_host && cv);
      r = cv && !g;
      e = pack(g, r, 0, g && hwr, g && !hwr, g ? ha : 3'd0, g ? hd : 8'd0, 0, 0);
      if (r) begin
        if (dv == 16'd0) begin
          seq.push_back(pack(0, 0, 1, 0, 0, 3'd0, 8'd0, 1, 1));
        end else begin
          seq.push_back(pack(0, 0, 1, 1, 0, 3'd3, 8'h80, 0, 0));
          seq.push_back(pack(0, 0, 1, 1, 0, 3'd0, dv[7:0], 0, 0));
          seq.push_back(pack(0, 0, 1, 1, 0, 3'd1, dv[15:8], 0, 0));
          seq.push_back(pack(0, 0, 1, 1, 0, 3'd3, {1'b0, lc[6:0]}, 0, 0));
          seq.push_back(pack(0, 0, 1, 1, 0, 3'd2, fc, 0, 0));
          seq.push_back(pack(0, 0, 1, 0, 0, 3'd0, 8'd0, 1, 0));
        end
      end
      last_host = g;
    end else begin
      e = seq.pop_front();
      last_host = 1'b0;
    end
    exp_q.push_back('{cyc, e});
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_drive(1, 0, 0, 3'd0, 8'd0, 0, 16'd0, 8'd0, 8'd0);
  endtask

  task automatic cfg(input logic [15:0] dv, input logic [7:0] lc, input logic [7:0] fc);
    cyc_drive(1, 0, 0, 3'd0, 8'd0, 1, dv, lc, fc);
  endtask

  task automatic host(input bit hwr, input logic [2:0] a, input logic [7:0] d);
    cyc_drive(1, 1, hwr, a, d, 0, 16'd0, 8'd0, 8'd0);
  endtask

  // Monitor: compare every driven cycle against the model's prediction.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("bus@%0d", e.cyc),
          {14'd0, host_gnt_o, cfg_ready_o, busy_o, wr_o, rd_o, addr_o, din_o, done_o, err_o},
          {14'd0, e.bus});
      chk($sformatf("excl@%0d", e.cyc), {31'd0, host_gnt_o && cfg_ready_o}, 32'd0);
    end
  end

  // Minimal regs_uart image, updated by whatever the DUT writes.
  always @(negedge clk) begin
    if (rst_n && wr_o) begin
      case (addr_o)
        3'd0: if (m_lcr[7]) m_dll = din_o;
        3'd1: if (m_lcr[7]) m_dlm = din_o;
        3'd3: m_lcr = din_o;
        default: ;
      endcase
    end
  end

  initial begin
    repeat (3) cyc_drive(0, 0, 0, 3'd0, 8'd0, 0, 16'd0, 8'd0, 8'd0);
    idle(1);

    cfg(16'h0108, 8'h9B, 8'h07);
    idle(7);
    @(negedge clk); #1;
    chk("divisor_a", {16'd0, m_dlm, m_dll}, 32'h0108);
    chk("lcr_a", {24'd0, m_lcr}, 32'h1B);

    cfg(16'h0000, 8'h03, 8'h01);
    idle(3);

    cfg(16'h0010, 8'h03, 8'h00);
    repeat (9) host(1, 3'd7, 8'h5A);
    idle(1);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] dv;
      dv = 16'($urandom_range(1, 16'hFFFF));
      cyc_drive(1, 1, 1'($urandom), 3'($urandom), 8'($urandom), 1, dv,
                8'($urandom), 8'($urandom));
    end
    idle(8);

    cfg(16'h0203, 8'h83, 8'hC1);
    idle(2);
    cyc_drive(0, 1, 1, 3'd4, 8'h33, 1, 16'h0404, 8'h03, 8'h00);
    cyc_drive(0, 0, 0, 3'd0, 8'd0, 0, 16'd0, 8'd0, 8'd0);
    idle(1);
    cfg(16'h0305, 8'h03, 8'h07);
    idle(7);
    @(negedge clk); #1;
    chk("divisor_b", {16'd0, m_dlm, m_dll}, 32'h0305);
    chk("lcr_b", {24'd0, m_lcr}, 32'h03);

    host(0, 3'd5, 8'hFF);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] dv;
      bit rn;
      rn = ($urandom_range(0, 99) != 0);
      dv = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      cyc_drive(rn, 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0), dv, 8'($urandom), 8'($urandom));
    end
    idle(8);
    @(negedge clk); #1;
    chk("drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cfg_sequencer.md
# uart_cfg_sequencer

Programs the 16550-style UART register block (`regs_uart`) and shares its register write/read bus between a host port and an internal configuration sequencer. A configuration request carries a divisor, a line-control byte and a FIFO-control byte. The block issues the fixed write sequence as one atomic burst, so no host access can land while DLAB=1: set DLAB, DLL, DLM, clear DLAB with final LCR, then FCR. It sits between the system bus adapter and `regs_uart`.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid_i` in 1: configuration request valid.
- `cfg_ready_o` out 1: sequencer accepts a request this cycle.
- `cfg_div_i` in 16: baud divisor; [7:0] goes to DLL, [15:8] to DLM.
- `cfg_lcr_i` in 8: line control; bit 7 is ignored.
- `cfg_fcr_i` in 8: FIFO control byte.
- `host_req_i` in 1: host wants a single-cycle register access.
- `host_wr_i` in 1: 1 = write, 0 = read.
- `host_addr_i` in 3: host register address.
- `host_din_i` in 8: host write data.
- `host_gnt_o` out 1: host access is driven on the bus this cycle (combinational).
- `wr_o`, `rd_o` out 1 each: to `regs_uart` `wr_i` / `rd_i`.
- `addr_o` out 3: to `regs_uart` `addr_i`.
- `din_o` out 8: to `regs_uart` `din_i`.
- `busy_o` out 1: sequence in progress.
- `done_o` out 1: one-cycle pulse when a request completes.
- `err_o` out 1: one-cycle pulse, coincident with `done_o`, when the request was rejected.

## Operation
- States: IDLE, DLAB_SET, DLL, DLM, LCR, FCR, DONE.
- IDLE:
  - `cfg_ready_o` = `cfg_valid_i` qualified by arbitration (see below).
  - A handshake latches `cfg_div_i`, `cfg_lcr_i` and `cfg_fcr_i` into internal registers.
  - The block then moves to DLAB_SET, or to DONE with an error flag if `cfg_div_i` = 0.
- Each write state asserts `wr_o`=1 for exactly one cycle:
  - DLAB_SET: addr 3, data 0x80.
  - DLL: addr 0, data div[7:0].
  - DLM: addr 1, data div[15:8].
  - LCR: addr 3, data {1'b0, lcr[6:0]}.
  - FCR: addr 2, data fcr.
- DONE: `done_o`=1 (and `err_o`=1 if flagged), then back to IDLE. The error flag clears.
- Divisor 0: the request is accepted, no bus writes are issued, and `done_o` and `err_o` pulse one cycle later.
- Arbitration, evaluated only in IDLE:
  - Host has priority, except that if the host was granted in the previous cycle and `cfg_valid_i` is high, cfg wins. This prevents starvation.
  - `host_gnt_o` and `cfg_ready_o` are never both 1.
  - Host grant: `wr_o`=`host_wr_i`, `rd_o`=~`host_wr_i`, `addr_o`/`din_o` pass through, all combinational.
- Outside IDLE: `host_gnt_o`=0 and `cfg_ready_o`=0. The host holds `host_req_i` until granted.
- Bus outputs when no access is driven: `wr_o`=`rd_o`=0, `addr_o`=0, `din_o`=0.
- `busy_o` = 1 in any state other than IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, last-grant flag 0, error flag 0. All outputs 0 except the combinational `host_gnt_o`/`cfg_ready_o`, which may assert in the first cycle after release.
- Handshake at edge N:
  - Writes are driven in cycles N+1 through N+5 (DLAB_SET, DLL, DLM, LCR, FCR).
  - `done_o` is high in cycle N+6.
  - IDLE is reached at N+7, so the earliest next handshake is at edge N+7.
- Divisor 0: `done_o`/`err_o` high in cycle N+1; IDLE again at N+2.
- Host access: zero latency. `regs_uart` samples the bus on the edge that ends the grant cycle.
- Reset asserted mid-sequence: the block aborts immediately and no `done_o` is produced. Partially written registers in `regs_uart` are left as they are, and DLAB may remain 1. Recovery is the next configuration request, which rewrites LCR.
- Back-to-back host requests with `cfg_valid_i` high: host granted in cycle k, cfg accepted in k+1, host blocked until the sequence ends.

## Structure
- Shared package `uart_pkg` holds:
  - Address constants: `ADDR_RBR_THR_DLL`=0, `ADDR_IER_DLM`=1, `ADDR_FCR`=2, `ADDR_LCR`=3.
  - `LCR_DLAB_BIT`=7.
  - State enum `cfg_state_t`.
- Single module; no sub-module. The arbiter is a few lines inside the IDLE decode.

## Test plan
- Reset, then a cfg request with div=0x0108, lcr=0x9B, fcr=0x07. Required writes, in consecutive cycles: (3,0x80), (0,0x08), (1,0x01), (3,0x1B), (2,0x07). `done_o` follows one cycle after the last write. `regs_uart` divisor reads 0x0108 with DLAB=0.
- cfg request with div=0. Required: no `wr_o` pulses, and `done_o`=`err_o`=1 in cycle N+1.
- `host_req_i` held high throughout a running sequence. Required: `host_gnt_o` stays 0 until IDLE, then the host is granted in the cycle after `done_o`.
- `host_req_i` and `cfg_valid_i` high every cycle. Required: grants alternate host, cfg, then the full 7-cycle sequence, then host again. `host_gnt_o` and `cfg_ready_o` are never both high.
- `rst_n` asserted during the DLM state. Required: outputs go 0 asynchronously, no `done_o` is produced, and a subsequent request completes normally and leaves DLAB=0.
- Host read (`host_wr_i`=0, addr 5). Required: `rd_o`=1, `wr_o`=0, `addr_o`=5 in the same cycle as the grant.
